// File: rtl/ssio_ddr_out_pkg.sv
// Shared types and sizing helpers for the source-synchronous DDR transmitter.
package ssio_ddr_out_pkg;

    typedef enum logic [1:0] {
        STOPPED,
        WAKE,
        ACTIVE,
        HOLD
    } state_t;

    // Counter must hold max(WAKE_CYCLES, HOLD_CYCLES, 1).
    function automatic int cnt_bits(input int wake, input int hold);
        int m;
        m = 1;
        if (wake > m) m = wake;
        if (hold > m) m = hold;
        return $clog2(m + 1);
    endfunction

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ssio_ddr_out_if.sv
// Word stream in, oddr bit pairs and status out.
interface ssio_ddr_out_if #(
    parameter int WIDTH = 4
);
    logic [2*WIDTH-1:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic [WIDTH-1:0]   output_d1;
    logic [WIDTH-1:0]   output_d2;
    logic               output_en;
    logic               output_clk_d1;
    logic               output_clk_d2;
    logic               status_active;

    modport master (
        output s_data, s_valid,
        input  s_ready,
        input  output_d1, output_d2, output_en,
        input  output_clk_d1, output_clk_d2,
        input  status_active
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready,
        output output_d1, output_d2, output_en,
        output output_clk_d1, output_clk_d2,
        output status_active
    );
endinterface

// File: rtl/ssio_ddr_out_fifo.sv
// First-word-fall-through FIFO with registered occupancy count.
module ssio_ddr_out_fifo
    import ssio_ddr_out_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int PTR_W = ptr_bits(DEPTH);

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ssio_ddr_out_tx.sv
// DDR transmit front end with clock-gating FSM.
// Optional SSIO_DDR_OUT_STATS_EN adds word/burst counters.
module ssio_ddr_out_tx
    import ssio_ddr_out_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               DEPTH       = 4,
    parameter int               WAKE_CYCLES = 2,
    parameter int               HOLD_CYCLES = 4,
    parameter logic [WIDTH-1:0] IDLE_VALUE  = '0
) (
    input  logic        clk,
    input  logic        rst,
    ssio_ddr_out_if.slave io
`ifdef SSIO_DDR_OUT_STATS_EN
    ,
    output logic [31:0] stat_words,
    output logic [15:0] stat_bursts
`endif
);
    localparam int CNT_W = cnt_bits(WAKE_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LOAD =
        CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   d1_q;
    logic [WIDTH-1:0]   d2_q;
    logic               en_q;
    logic               clk_q;
    logic [2*WIDTH-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign io.s_ready = !full && !rst;
    assign push       = io.s_valid && io.s_ready;
    assign pop        = ((state == ACTIVE) || (state == HOLD)) && !empty;

    ssio_ddr_out_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (io.s_data),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Output regs follow the next state so the clock pair never truncates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOPPED;
            cnt   <= '0;
            d1_q  <= IDLE_VALUE;
            d2_q  <= IDLE_VALUE;
            en_q  <= 1'b0;
            clk_q <= 1'b0;
        end else begin
            d1_q  <= IDLE_VALUE;
            d2_q  <= IDLE_VALUE;
            en_q  <= 1'b0;
            clk_q <= 1'b1;
            unique case (state)
                STOPPED: begin
                    if (empty) begin
                        clk_q <= 1'b0;
                    end else if (WAKE_CYCLES == 0) begin
                        state <= ACTIVE;
                    end else begin
                        state <= WAKE;
                        cnt   <= WAKE_LOAD;
                    end
                end
                WAKE: begin
                    if (cnt == '0) state <= ACTIVE;
                    else           cnt   <= cnt - 1'b1;
                end
                ACTIVE: begin
                    if (!empty) begin
                        d1_q <= head[WIDTH-1:0];
                        d2_q <= head[2*WIDTH-1:WIDTH];
                        en_q <= 1'b1;
                    end else if (HOLD_CYCLES == 0) begin
                        state <= STOPPED;
                        clk_q <= 1'b0;
                    end else begin
                        state <= HOLD;
                        cnt   <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (!empty) begin
                        state <= ACTIVE;
                        d1_q  <= head[WIDTH-1:0];
                        d2_q  <= head[2*WIDTH-1:WIDTH];
                        en_q  <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= STOPPED;
                        clk_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= STOPPED;
            endcase
        end
    end

    assign io.output_d1     = d1_q;
    assign io.output_d2     = d2_q;
    assign io.output_en     = en_q;
    assign io.output_clk_d1 = clk_q;
    assign io.output_clk_d2 = 1'b0;
    assign io.status_active = (state != STOPPED);

`ifdef SSIO_DDR_OUT_STATS_EN
    logic start;
    assign start = (state == STOPPED) && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words  <= '0;
            stat_bursts <= '0;
        end else begin
            if (pop && (stat_words != '1))
                stat_words <= stat_words + 1'b1;
            if (start && (stat_bursts != '1))
                stat_bursts <= stat_bursts + 1'b1;
        end
    end
`endif
endmodule
